// File: rtl/alu_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_pkg
// Description : Shared UART definitions (frame shape, idle level, receiver
//               state encoding) used by the ALU UART receiver and transmitter.
// Revision    : 1.0  initial release
// ============================================================================
package alu_uart_pkg;

  localparam int   UART_DATA_BITS            = 8;
  localparam logic UART_IDLE_LEVEL           = 1'b1;
  localparam int   UART_CLKS_PER_BIT_DEFAULT = 104;

  // Receiver states; PARITY is only reachable when parity checking is built in
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_e;

endpackage : alu_uart_pkg
`default_nettype wire

// File: rtl/alu_uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_sync2
// Description : Two-flop synchronizer for a single asynchronous bit. Resets
//               to the UART idle level so a reset never looks like a start bit.
// Revision    : 1.0  initial release
// ============================================================================
module alu_uart_sync2
  import alu_uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the async input through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, preset to idle level
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : alu_uart_sync2
`default_nettype wire

// File: rtl/alu_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_rx
// Description : UART receiver (8 data bits, LSB first, 1 stop bit) with a
//               single-entry valid/ready holding register, frame-error and
//               overrun pulses. Optional even-parity check is built in when
//               the macro UART_RX_PARITY_EN is defined (8E1 frame).
// Revision    : 1.0  initial release
// ============================================================================
module alu_uart_rx
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  // Baud counter counts down to zero and samples there; it is reloaded for
  // every bit so it never wraps. START waits CLKS_PER_BIT/2 cycles, which
  // also rejects low glitches shorter than that window.
  localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  logic rxd_s;

  uart_rx_state_e            state_q,    state_d;
  logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]          bit_cnt_q,  bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
  logic [UART_DATA_BITS-1:0] data_q,     data_d;
  logic                      valid_q,    valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q,  overrun_d;

  logic w_baud_done;
  logic w_busy;
  logic w_stop_hit;
  logic w_frame_bad;
  logic w_byte_good;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q,    par_bad_d;
  logic parity_err_q, parity_err_d;
  logic w_par_hit;
`endif

  alu_uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rxd),
    .q     (rxd_s)
  );

  assign w_baud_done = (baud_cnt_q == '0);

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, baud/bit counters, shift register
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = w_baud_done ? '0 : (baud_cnt_q - CNT_W'(1));
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rxd_s != UART_IDLE_LEVEL) begin
          state_d    = ST_START;
          baud_cnt_d = BAUD_HALF;
          bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          if (rxd_s == UART_IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_DATA;
            baud_cnt_d = BAUD_FULL;
          end
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          shift_d    = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
          baud_cnt_d = BAUD_FULL;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_baud_done) begin
          par_bad_d  = (rxd_s != ^shift_q);
          baud_cnt_d = BAUD_FULL;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_baud_done) begin
          state_d = (rxd_s == UART_IDLE_LEVEL) ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rxd_s == UART_IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from current state: busy flag and frame-end events
  always_comb begin
    w_busy      = (state_q != ST_IDLE);
    w_stop_hit  = (state_q == ST_STOP) && w_baud_done;
    w_frame_bad = w_stop_hit && (rxd_s != UART_IDLE_LEVEL);
    w_byte_good = w_stop_hit && (rxd_s == UART_IDLE_LEVEL);
`ifdef UART_RX_PARITY_EN
    w_byte_good = w_byte_good && !par_bad_q;
    w_par_hit   = (state_q == ST_PARITY) && w_baud_done && (rxd_s != ^shift_q);
`endif
  end

  // Holding register handshake and one-cycle error pulses
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = w_frame_bad;
`ifdef UART_RX_PARITY_EN
    parity_err_d = w_par_hit;
`endif
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (w_byte_good) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = w_busy;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule : alu_uart_rx
`default_nettype wire

// File: tb/tb_alu_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_uart_rx
// Description : Self-checking bench for alu_uart_rx at CLKS_PER_BIT=4.
//               Parity cases are included when UART_RX_PARITY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_uart_rx;

  localparam int CPB = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  // Event counters written only by the monitor
  int cyc = 0;
  int n_vcyc = 0, n_hs = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, last_hs_cyc = 0;
  logic [7:0] got_mem [0:255];

  // Snapshots taken by the stimulus process
  int s_vcyc, s_hs, s_ferr, s_ovr, s_perr;
  int end_cyc;
  logic [7:0] exp_q [$];
  logic [7:0] b;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  alu_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) n_vcyc <= n_vcyc + 1;
      if (rx_valid && rx_ready) begin
        got_mem[n_hs & 255] <= rx_data;
        n_hs        <= n_hs + 1;
        last_hs_cyc <= cyc;
      end
      if (frame_err)  n_ferr <= n_ferr + 1;
      if (overrun)    n_ovr  <= n_ovr + 1;
      if (parity_err) n_perr <= n_perr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_t(input logic v);
    uart_rxd = v;
    idle(CPB);
  endtask

  task automatic snap();
    s_vcyc = n_vcyc; s_hs = n_hs; s_ferr = n_ferr; s_ovr = n_ovr; s_perr = n_perr;
  endtask

  // One frame: start, 8 data LSB first, [even parity], stop. rst_bit >= 0
  // pulses reset for two cycles at the start of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        uart_rxd = d[i];
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(CPB - 2);
      end else begin
        bit_t(d[i]);
      end
    end
`ifdef UART_RX_PARITY_EN
    bit_t((^d) ^ par_flip);
`endif
    bit_t(stop);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    idle(4);

    // 0xA5 with consumer ready
    snap();
    send_frame(8'hA5, 1'b1, -1);
    end_cyc = cyc;
    idle(12);
    check("a5_hs", n_hs - s_hs, 1);
    check("a5_data", got_mem[s_hs & 255], 8'hA5);
    check("a5_vcyc", n_vcyc - s_vcyc, 1);
    check("a5_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr) + (n_perr - s_perr), 0);
    check("a5_lat", ((last_hs_cyc - end_cyc) >= 1) && ((last_hs_cyc - end_cyc) <= 4), 1);

    // Random bytes, random gaps, consumer always ready
    snap();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, -1);
      idle($urandom_range(0, 3));
    end
    idle(12);
    check("rnd_count", n_hs - s_hs, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_data%0d", i), got_mem[(s_hs + i) & 255], exp_q[i]);
    check("rnd_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);

    // Overrun: two bytes with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    idle(12);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h3C);
    check("ovr_pulse", n_ovr - s_ovr, 1);
    check("ovr_hs", n_hs - s_hs, 0);
    rx_ready = 1'b1;
    idle(1);
    check("ovr_drop", rx_valid, 0);
    check("ovr_take", got_mem[s_hs & 255], 8'h3C);
    snap();
    b = 8'($urandom);
    send_frame(b, 1'b1, -1);
    idle(12);
    check("ovr_next", got_mem[s_hs & 255], b);
    check("ovr_next_hs", n_hs - s_hs, 1);

    // Bad stop bit followed by a long break
    snap();
    send_frame(8'h55, 1'b0, -1);
    uart_rxd = 1'b0;
    idle(20 * CPB);
    uart_rxd = 1'b1;
    idle(12);
    check("brk_ferr", n_ferr - s_ferr, 1);
    check("brk_vcyc", n_vcyc - s_vcyc, 0);
    check("brk_busy", rx_busy, 0);
    snap();
    send_frame(8'h0F, 1'b1, -1);
    idle(12);
    check("brk_rec", got_mem[s_hs & 255], 8'h0F);
    check("brk_rec_hs", n_hs - s_hs, 1);

    // Glitches on the idle line
    snap();
    uart_rxd = 1'b0;
    idle(1);
    uart_rxd = 1'b1;
    idle(10);
    uart_rxd = 1'b0;
    idle(CPB - 1);
    uart_rxd = 1'b1;
    idle(1);
    check("gl_busy_mid", rx_busy, 1);
    idle(10);
    check("gl_busy", rx_busy, 0);
    check("gl_vcyc", n_vcyc - s_vcyc, 0);
    check("gl_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr) + (n_perr - s_perr), 0);

    // Reset during bit 4 of 0xFF
    snap();
    send_frame(8'hFF, 1'b1, 4);
    idle(12);
    check("rm_hs", n_hs - s_hs, 0);
    check("rm_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr) + (n_perr - s_perr), 0);
    check("rm_busy", rx_busy, 0);
    check("rm_data", rx_data, 0);
    snap();
    send_frame(8'h12, 1'b1, -1);
    idle(12);
    check("rm_next", got_mem[s_hs & 255], 8'h12);
    check("rm_next_hs", n_hs - s_hs, 1);

`ifdef UART_RX_PARITY_EN
    snap();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, -1);
    idle(12);
    check("par_ok", got_mem[s_hs & 255], 8'h07);
    check("par_ok_hs", n_hs - s_hs, 1);
    check("par_ok_perr", n_perr - s_perr, 0);
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, -1);
    par_flip = 1'b0;
    idle(12);
    check("par_bad_perr", n_perr - s_perr, 1);
    check("par_bad_hs", n_hs - s_hs, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_uart_rx
`default_nettype wire

// File: doc/alu_uart_rx.md
ALU_UART_RX -- requirements
Module: alu_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit period (legal minimum 4).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  holding register contains an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1 on a clk edge.
REQ-008 SHALL have port rx_busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without UART_RX_PARITY_EN.

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer (reset value 1) before any use; all timing below refers to the synchronized signal.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-014 IDLE: on synchronized line = 0, SHALL enter START with bit counter cleared and baud counter loaded for half a bit period.
REQ-015 START: after CLKS_PER_BIT/2 cycles SHALL sample; 1 -> IDLE (glitch, no flags), 0 -> DATA.
REQ-016 DATA: SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register; after bit 7 -> PARITY if enabled, else STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles SHALL sample; 1 -> deliver byte and IDLE; 0 -> pulse frame_err, discard byte, -> WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL stay until the line reads 1, then IDLE (break condition yields exactly one frame_err).
REQ-019 Delivery: if holding register empty, or rx_valid&rx_ready in that same cycle, SHALL load rx_data and set rx_valid the next edge.
REQ-020 Delivery with rx_valid=1 and rx_ready=0 SHALL keep the old byte, drop the new one, and pulse overrun.
REQ-021 rx_valid SHALL clear on handshake unless a new byte loads in the same cycle; rx_data SHALL not change while rx_valid=1 and rx_ready=0.
REQ-022 Latency: rx_valid SHALL rise no later than 3 clk cycles after the stop-bit sample point plus synchronizer delay.
REQ-023 Baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and reload, never wrap freely.

Reset
REQ-024 reset SHALL force state IDLE, rx_data=0, rx_valid=0, rx_busy=0, all error pulses 0, synchronizer flops=1, counters=0.
REQ-025 reset asserted mid-frame SHALL abandon the frame with no flags; reception restarts only on a new falling edge after release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined SHALL add state PARITY: sample one bit after data; mismatch against even parity of the 8 data bits -> pulse parity_err, discard byte, still proceed to STOP.
REQ-027 Without UART_RX_PARITY_EN the frame SHALL be 8N1, PARITY state and its logic absent, parity_err constant 0.

Structure
REQ-028 Package alu_uart_pkg SHALL hold the state enum, UART_DATA_BITS=8, UART_IDLE_LEVEL=1, default CLKS_PER_BIT; shared with the ALU transmitter.
REQ-029 Synchronizer SHALL be sub-module alu_uart_sync2 (parameterless, 1-bit, reset value as REQ-024).

Verification (bench CLKS_PER_BIT=4)
REQ-030 Send 0xA5 8N1, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, no error pulses.
REQ-031 Send 0x3C then 0x81 with rx_ready=0 -> rx_data stays 0x3C, one overrun pulse; then rx_ready=1 -> rx_valid drops, next byte accepted normally.
REQ-032 Send 0x55 with stop bit 0, line held 0 for 20 bit times -> exactly one frame_err, no rx_valid, recovers and receives 0x0F afterwards.
REQ-033 1-cycle and 1-bit-minus-1 low glitches on idle line -> no rx_valid, no flags, rx_busy returns 0.
REQ-034 reset pulse during bit 4 of 0xFF -> no output; following 0x12 received correctly.
REQ-035 With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_data=0x07; with parity 0 -> parity_err pulse, no rx_valid.
